memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_pkg.sv | 19 +
 rtl/memory_array.sv | 42 ++++
 rtl/memory_responder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared widths, FSM state encoding and transfer-direction
// constants for the memory_responder block and its storage sub-module.
package memory_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Encoding of the wr_rd request bit.
  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

endpackage : memory_pkg

// File: rtl/memory_array.sv
// memory_array: DEPTH x DATA_W word store with a synchronous write port and a
// registered read port. Synchronous reset clears every word and the read
// register.
//   clk      - clock
//   rst      - synchronous active-high reset
//   we_i     - write enable: mem[addr_i] <= wdata_i
//   re_i     - read enable:  rdata_o <= mem[addr_i]
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - registered read data; holds between reads
module memory_array
  import memory_pkg::*;
#(
  parameter int DEPTH_P = DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_P];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array is cleared word-by-word on reset, so it maps to flops
  // rather than a RAM macro; this is required because reset must zero memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_P; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : memory_array

// File: rtl/memory_responder.sv
// memory_responder: single-outstanding memory slave. A request (sel=1) is
// captured in IDLE, held for WAIT_CYCLES cycles, then completed with a
// one-cycle ready strobe. Writes commit and reads load rdata on the edge
// entering ACK.
//   clk    - clock, all state changes on rising edge
//   rst    - synchronous active-high reset
//   sel    - request valid, held until ready is sampled high
//   wr_rd  - 1 = write, 0 = read
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
//   ready  - registered one-cycle completion strobe
module memory_responder
  import memory_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_P     = DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;

  // Access signals presented to the array on the edge entering ACK. With
  // WAIT_CYCLES = 0 that edge is also the capture edge, so the live inputs
  // are used instead of the not-yet-loaded capture registers.
  logic              enter_ack;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_wr;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    enter_ack = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wr    = wr_q;

    unique case (state_q)
      IDLE: begin
        if (sel) begin
          addr_d    = addr;
          wdata_d   = wdata;
          wr_d      = wr_rd;
          acc_addr  = addr;
          acc_wdata = wdata;
          acc_wr    = wr_rd;
          if (WAIT_CYCLES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        // Count of 1 means this is the last wait edge.
        if (cnt_q <= 4'd1) begin
          state_d   = ACK;
          cnt_d     = 4'd0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;  // sel is deliberately ignored here
      default: state_d = IDLE;
    endcase

    ready_d = enter_ack;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= READ;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
    end
  end

  memory_array #(.DEPTH_P(DEPTH_P)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (enter_ack && (acc_wr == WRITE)),
    .re_i    (enter_ack && (acc_wr == READ)),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .rdata_o (rdata)
  );

  assign ready = ready_q;

endmodule : memory_responder
